// File: rtl/frame_sdram_writer.sv
// Packs a camera byte stream into RGB565 words, buffers them in a small FIFO and
// writes one frame to SDRAM at consecutive word addresses over Avalon-MM.
module frame_sdram_writer #(
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200,
    parameter int BASE_ADDR   = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clock_hf,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [1:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic [15:0]       sdram_writedata,
    output logic              sdram_write_n,
    output logic              sdram_read_n,
    input  logic              sdram_waitrequest
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W:0]   words_pushed_r, words_written_r, written_next_s;
    logic              phase_lo_r;
    logic [7:0]        hi_byte_r;
    logic [15:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [PTR_W:0]    count_r, remain_s;
    logic              start_s, byte_ok_s, push_s, pop_s, accept_s, drop_s, req_next_s;
    logic              busy_r, done_r, overflow_r, cs_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;

    assign busy               = busy_r;
    assign done               = done_r;
    assign overflow           = overflow_r;
    assign sdram_chipselect   = cs_r;
    assign sdram_write_n      = ~cs_r;
    assign sdram_address      = addr_r;
    assign sdram_writedata    = wdata_r;
    assign sdram_byteenable_n = 2'b00;
    assign sdram_read_n       = 1'b1;

    // Frame state transitions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    if (frame_start) state_s = ST_CAPTURE; else state_s = ST_IDLE;
            ST_CAPTURE: if (words_pushed_r == FRAME_CNT) state_s = ST_FLUSH; else state_s = ST_CAPTURE;
            ST_FLUSH:   if (words_written_r == FRAME_CNT) state_s = ST_DONE; else state_s = ST_FLUSH;
            ST_DONE:    if (frame_start) state_s = ST_CAPTURE; else state_s = ST_DONE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Packing, FIFO bookkeeping and the next Avalon request.
    always_comb begin
        start_s   = (state_s == ST_CAPTURE) && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        byte_ok_s = (state_r == ST_CAPTURE) && (words_pushed_r < FRAME_CNT) && pix_valid;
        push_s    = byte_ok_s && phase_lo_r;
        pop_s     = cs_r && !sdram_waitrequest;
        accept_s  = push_s && ((count_r != FULL_CNT) || pop_s);
        drop_s    = push_s && !accept_s;
        written_next_s = words_written_r + (ADDR_W+1)'(pop_s);
        // Words pushed this very edge are not yet visible, so they start a request one cycle later.
        remain_s   = count_r - (PTR_W+1)'(pop_s);
        rd_next_s  = rd_ptr_r + PTR_W'(pop_s);
        req_next_s = (remain_s != '0) && ((state_r == ST_CAPTURE) || (state_r == ST_FLUSH));
    end

    // State register.
    always_ff @(posedge clock_hf or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Byte pairing, word FIFO, counters and status flags.
    always_ff @(posedge clock_hf or negedge reset) begin
        if (!reset) begin
            words_pushed_r  <= '0;
            words_written_r <= '0;
            phase_lo_r      <= 1'b0;
            hi_byte_r       <= 8'h00;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            count_r         <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            overflow_r      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 16'h0000;
        end else if (start_s) begin
            words_pushed_r  <= '0;
            words_written_r <= '0;
            phase_lo_r      <= 1'b0;
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            count_r         <= '0;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            if (byte_ok_s) begin
                phase_lo_r <= ~phase_lo_r;
                if (!phase_lo_r) hi_byte_r <= pix_data;
            end
            if (push_s) words_pushed_r <= words_pushed_r + (ADDR_W+1)'(1);
            if (accept_s) begin
                mem_r[wr_ptr_r] <= {hi_byte_r, pix_data};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (drop_s) overflow_r <= 1'b1;
            words_written_r <= written_next_s;
            rd_ptr_r        <= rd_next_s;
            count_r         <= count_r + (PTR_W+1)'(accept_s) - (PTR_W+1)'(pop_s);
            if ((state_r == ST_FLUSH) && (state_s == ST_DONE)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    // Registered Avalon request; a stalled request keeps its head word and address.
    always_ff @(posedge clock_hf or negedge reset) begin
        if (!reset) begin
            cs_r    <= 1'b0;
            addr_r  <= BASE;
            wdata_r <= 16'h0000;
        end else begin
            cs_r   <= req_next_s && !start_s;
            addr_r <= start_s ? BASE : (BASE + written_next_s[ADDR_W-1:0]);
            if (req_next_s && !start_s) wdata_r <= mem_r[rd_next_s];
        end
    end
endmodule

// File: tb/tb_frame_sdram_writer.sv
// Scoreboard bench for frame_sdram_writer: expected writes are queued as bytes are
// driven and matched against completed Avalon writes.
module tb_frame_sdram_writer;
    localparam int          ADDR_W = 22;
    localparam logic [21:0] BASE_V = 22'h3FFFFE;

    logic        clock_hf = 1'b0;
    logic        reset, frame_start, pix_valid, waitreq;
    logic [7:0]  pix_data;
    logic        busy, done, overflow, cs, write_n, read_n;
    logic [21:0] addr;
    logic [1:0]  be_n;
    logic [15:0] wdata;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_writes = 0;
    int           word_idx = 0;
    int           wr_mode  = 0;
    logic [37:0]  exp_q[$];

    frame_sdram_writer #(.ADDR_W(22), .FRAME_WORDS(4), .BASE_ADDR('h3FFFFE), .FIFO_DEPTH(2)) dut (
        .clock_hf(clock_hf), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .busy(busy), .done(done),
        .overflow(overflow), .sdram_address(addr), .sdram_byteenable_n(be_n),
        .sdram_chipselect(cs), .sdram_writedata(wdata), .sdram_write_n(write_n),
        .sdram_read_n(read_n), .sdram_waitrequest(waitreq)
    );

    always #5 clock_hf = ~clock_hf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_hf);
            #1;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Drive n bytes from 'first' upward; the first n_expect words are queued as expected writes.
    task automatic send_bytes(input logic [7:0] first, input int n, input int gap, input int n_expect);
        logic [7:0]  b, hi;
        logic [21:0] a;
        hi = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            if ((i % 2) == 0) hi = b;
            else begin
                if (word_idx < n_expect) begin
                    a = BASE_V + 22'(word_idx);
                    exp_q.push_back({a, hi, b});
                end
                word_idx++;
            end
            pix_valid = 1'b1;
            pix_data  = b;
            tick(1);
            pix_valid = 1'b0;
            tick(gap);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick(1);
            k++;
        end
        check_val("done_timeout", 32'(done), 32'd1);
    endtask

    // Slave model: no stall, three stall cycles per write, or stalled continuously.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        waitreq = 1'b0;
        forever begin
            @(posedge clock_hf);
            #1;
            case (wr_mode)
                0: waitreq = 1'b0;
                1: begin
                    if (cs && !write_n) begin
                        if (stall_cnt < 3) begin
                            waitreq = 1'b1;
                            stall_cnt++;
                        end else begin
                            waitreq = 1'b0;
                            stall_cnt = 0;
                        end
                    end else waitreq = 1'b0;
                end
                default: waitreq = 1'b1;
            endcase
        end
    end

    // Write monitor: held request stability and scoreboard matching.
    initial begin
        logic        prev_stalled;
        logic [21:0] prev_addr;
        logic [15:0] prev_data;
        logic [37:0] e;
        prev_stalled = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clock_hf);
            if (reset && cs && !write_n) begin
                if (prev_stalled) begin
                    check_val("stall_addr", 32'(addr), 32'(prev_addr));
                    check_val("stall_data", 32'(wdata), 32'(prev_data));
                end
                if (!waitreq) begin
                    check_val("write_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("write_addr", 32'(addr), 32'(e[37:16]));
                        check_val("write_data", 32'(wdata), 32'(e[15:0]));
                    end
                    n_writes++;
                end
                prev_stalled = waitreq;
                prev_addr = addr;
                prev_data = wdata;
            end else prev_stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_data = 8'h00;
        tick(3);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        check_val("rst_cs", 32'(cs), 32'd0);
        check_val("rst_write_n", 32'(write_n), 32'd1);
        check_val("rst_read_n", 32'(read_n), 32'd1);
        check_val("rst_addr", 32'(addr), 32'(BASE_V));
        check_val("rst_wdata", 32'(wdata), 32'd0);
        check_val("byteenable_n", 32'(be_n), 32'd0);
        reset = 1'b1;
        tick(2);

        // Back-to-back bytes, no stall, addresses wrap past the top.
        word_idx = 0; n_writes = 0; wr_mode = 0;
        pulse_start();
        check_val("busy_armed", 32'(busy), 32'd1);
        send_bytes(8'h01, 8, 0, 4);
        wait_done(100);
        check_val("t1_busy", 32'(busy), 32'd0);
        check_val("t1_ovf", 32'(overflow), 32'd0);
        check_val("t1_writes", 32'(n_writes), 32'd4);
        check_val("t1_queue", 32'(exp_q.size()), 32'd0);

        // Re-arm from DONE, three stall cycles per write.
        word_idx = 0; n_writes = 0; wr_mode = 1;
        pulse_start();
        check_val("t2_done_clr", 32'(done), 32'd0);
        send_bytes(8'h11, 8, 3, 4);
        wait_done(200);
        check_val("t2_ovf", 32'(overflow), 32'd0);
        check_val("t2_writes", 32'(n_writes), 32'd4);
        check_val("t2_queue", 32'(exp_q.size()), 32'd0);

        // Sparse bytes, ignored mid-frame start, surplus bytes after the frame.
        word_idx = 0; n_writes = 0; wr_mode = 0;
        pulse_start();
        send_bytes(8'hA0, 4, 4, 4);
        pulse_start();
        send_bytes(8'hA4, 4, 4, 4);
        send_bytes(8'hC0, 6, 0, 4);
        wait_done(200);
        tick(10);
        check_val("t3_writes", 32'(n_writes), 32'd4);
        check_val("t3_queue", 32'(exp_q.size()), 32'd0);
        check_val("t3_busy", 32'(busy), 32'd0);

        // Continuous stall while the frame streams: overflow, only the FIFO contents land.
        word_idx = 0; n_writes = 0; wr_mode = 2;
        pulse_start();
        send_bytes(8'h31, 8, 0, 2);
        tick(12);
        wr_mode = 0;
        tick(15);
        check_val("t4_ovf", 32'(overflow), 32'd1);
        check_val("t4_done", 32'(done), 32'd0);
        check_val("t4_busy", 32'(busy), 32'd1);
        check_val("t4_writes", 32'(n_writes), 32'd2);
        check_val("t4_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during a stalled write, then a clean restart.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        word_idx = 0; wr_mode = 2;
        pulse_start();
        send_bytes(8'h51, 2, 0, 0);
        tick(3);
        check_val("t5_req_held", 32'(cs), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_rst_write_n", 32'(write_n), 32'd1);
        check_val("t5_rst_cs", 32'(cs), 32'd0);
        check_val("t5_rst_busy", 32'(busy), 32'd0);
        tick(1);
        reset = 1'b1;
        wr_mode = 0;
        tick(2);
        word_idx = 0; n_writes = 0;
        pulse_start();
        send_bytes(8'h61, 8, 1, 4);
        wait_done(100);
        check_val("t5_writes", 32'(n_writes), 32'd4);
        check_val("t5_queue", 32'(exp_q.size()), 32'd0);
        check_val("t5_ovf", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/frame_sdram_writer.md
Name: frame_sdram_writer

Overview:
- Upstream stage of the SDRAM controller in the frame-acquisition path.
- Collects a camera byte stream already synchronous to clock_hf and packs byte pairs into 16-bit RGB565 words.
- Buffers the words in a small FIFO and writes one frame to SDRAM at consecutive word addresses through the controller's Avalon-MM slave port, honouring waitrequest.
- Reports done when the frame has been written, or error on FIFO overflow.

Parameters:
- ADDR_W, 22, width of the SDRAM word address.
- FRAME_WORDS, 307200, number of 16-bit words per frame (640x480 RGB565); must be 1 to 2^ADDR_W.
- BASE_ADDR, 0, word address of the first frame word.
- FIFO_DEPTH, 8, number of word-FIFO entries; power of two, minimum 2.

Ports:
- clock_hf  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  single-cycle pulse that arms capture of one frame.
- pix_valid  input  1  pix_data holds a valid byte this cycle.
- pix_data  input  8  camera byte; the first byte of each pair is the high byte.
- busy  output  1  high from an accepted frame_start until done rises.
- done  output  1  sticky high after the last frame word has been written.
- overflow  output  1  sticky high if any word was dropped because the FIFO was full.
- sdram_address  output  ADDR_W  Avalon word address.
- sdram_byteenable_n  output  2  always 2'b00 (both bytes enabled).
- sdram_chipselect  output  1  Avalon chipselect.
- sdram_writedata  output  16  Avalon write data.
- sdram_write_n  output  1  active-low write request.
- sdram_read_n  output  1  tied to 1; this block never reads.
- sdram_waitrequest  input  1  slave stall; the request must be held while this is high.

Behaviour:
- Reset (async, reset=0) clears all outputs and state:
  - busy=0, done=0, overflow=0.
  - sdram_chipselect=0, sdram_write_n=1, sdram_read_n=1.
  - sdram_address=BASE_ADDR, sdram_writedata=0.
  - FIFO empty, byte phase=high, both counters 0, state IDLE.
  - Reset asserted mid-frame abandons the frame; no partial write is completed.
- States:
  - IDLE → CAPTURE on frame_start. This clears done, overflow, counters and the byte phase, and sets busy.
  - CAPTURE: accepts bytes while words_pushed < FRAME_WORDS and issues writes.
  - CAPTURE → FLUSH when words_pushed reaches FRAME_WORDS. Bytes are ignored from then on.
  - FLUSH → DONE when words_written == FRAME_WORDS. On entering DONE, busy=0 and done=1.
  - DONE → CAPTURE on frame_start (re-arm).
  - frame_start in CAPTURE or FLUSH is ignored.
- Packing:
  - In the high phase, pix_valid latches pix_data into [15:8] and toggles the phase.
  - In the low phase, pix_valid forms {hi, pix_data}; the word is pushed on the same edge and the phase returns to high.
  - pix_valid=0 holds the phase indefinitely.
- FIFO push rules:
  - If the FIFO is full and no pop happens the same cycle, the word is dropped and overflow is set.
  - A dropped word still increments words_pushed, so the frame length is fixed and the written frame is short.
  - Push and pop in the same cycle with the FIFO full: the push is accepted and the count is unchanged.
- Avalon write:
  - When the FIFO is non-empty in CAPTURE or FLUSH, drive sdram_chipselect=1, sdram_write_n=0, sdram_writedata=FIFO head, sdram_address=BASE_ADDR+words_written.
  - Hold all of these stable while sdram_waitrequest=1.
  - On an edge with the request active and waitrequest=0: pop the FIFO and increment words_written and the address.
  - If the FIFO is then empty, deassert the request the next cycle; otherwise present the next word with no idle cycle.
- Latency and throughput:
  - A word pushed into an empty FIFO at edge N is presented at edge N+1 (first cycle of the request).
  - With waitrequest=0, sustained throughput is one word per cycle.
- Width and wrap:
  - Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+FRAME_WORDS-1 wraps silently.
  - Counters are ADDR_W+1 bits wide so FRAME_WORDS=2^ADDR_W is representable.

Test Plan:
- Reset, then frame_start with FRAME_WORDS=4, bytes 01,02,03,04,05,06,07,08 back-to-back, waitrequest=0 → writes 0x0102@0, 0x0304@1, 0x0506@2, 0x0708@3; done=1 one cycle after the last write; busy=0; overflow=0.
- Same frame with waitrequest high for 3 cycles on each write → address and writedata held stable while stalled; each word written exactly once; done=1.
- FIFO_DEPTH=2, FRAME_WORDS=8, waitrequest held high for 20 cycles while 16 bytes stream → overflow=1; after release, exactly 2 words written and done stays 0.
- pix_valid gaps (one byte every 5 cycles) with BASE_ADDR=0x3FFFFE, FRAME_WORDS=3 → addresses 0x3FFFFE, 0x3FFFFF, 0x000000 written; correct byte pairing; done=1.
- Extra bytes after FRAME_WORDS words, and frame_start pulsed mid-frame → no extra writes; the mid-frame start is ignored.
- reset=0 asynchronously during a stalled write → write_n=1 and chipselect=0 immediately; after release, frame_start restarts cleanly at BASE_ADDR.
